// File: rtl/memory_pkg.sv
// Shared memory-subsystem types: WBB tag, WBB command encoding and the
// victim-buffer controller state and limits.
package memory_pkg;

    localparam int L1C_WBB_ENTRIES = 4;
    localparam int WBB_MAX_OUTST   = 2;

    typedef logic [2:0] wbb_tag_t;

    typedef enum logic [2:0] {
        CMD_NONE     = 3'd0,
        CMD_ADD      = 3'd1,
        CMD_PUT_WAIT = 3'd2,
        CMD_CLR      = 3'd3,
        CMD_SWITCH   = 3'd4,
        CMD_WUP      = 3'd5
    } wbb_cmd_e;

    typedef enum logic {
        IDLE = 1'b0,
        REQ  = 1'b1
    } wbb_ctrl_state_e;

endpackage

// File: rtl/dcache_wbb_tag_counter.sv
// Wrapping request-tag counter; advances by one on each accepted L2 write.
module dcache_wbb_tag_counter
    import memory_pkg::*;
(
    input  logic     clk_i,
    input  logic     rst_ni,
    input  logic     inc_i,
    output wbb_tag_t tag_o
);

    wbb_tag_t r_tag;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_tag <= '0;
        end else if (inc_i) begin
            r_tag <= r_tag + wbb_tag_t'(1);
        end
    end

    assign tag_o = r_tag;

endmodule

// File: rtl/dcache_wbb_ctrl.sv
// Write-back victim buffer controller: arbitrates L2 acks, D1 evictions and
// L2 write issue onto a single WBB command port, and tracks outstanding writes.
module dcache_wbb_ctrl
    import memory_pkg::*;
#(
    parameter int WBB_ENTRIES = L1C_WBB_ENTRIES,
    parameter int MAX_OUTST   = WBB_MAX_OUTST
) (
    input  logic     clk_i,
    input  logic     rst_ni,
    input  logic     evict_valid_i,
    output logic     evict_ready_o,
    input  logic     l2_ack_valid_i,
    input  wbb_tag_t l2_ack_tag_i,
    input  logic     l2_ack_retry_i,
    output logic     l2_ack_ready_o,
    output logic     l2_req_valid_o,
    output wbb_tag_t l2_req_tag_o,
    input  logic     l2_req_ready_i,
    input  logic     wbb_line_hit_i,
    input  logic     wbb_tag_hit_i,
    input  logic     wbb_req_avail_i,
    input  logic     wbb_full_i,
    output wbb_cmd_e wbb_cmd_o,
    output wbb_tag_t wbb_cmp_tag_o,
    output wbb_tag_t wbb_new_tag_o,
    output logic     spurious_ack_o
);

    localparam int TAG_W   = $bits(wbb_tag_t);
    localparam int OUTST_W = $clog2(MAX_OUTST + 1);

    // Tag wrap is only safe while fewer requests are in flight than tags exist.
    generate
        if (MAX_OUTST < 1 || MAX_OUTST > WBB_ENTRIES || MAX_OUTST >= (1 << TAG_W)) begin : g_bad_param
            $error("dcache_wbb_ctrl: MAX_OUTST out of range");
        end
    endgenerate

    wbb_ctrl_state_e    r_state;
    logic [OUTST_W-1:0] r_outst;
    wbb_tag_t           w_tag;
    logic               w_claim;
    logic               w_dec;
    logic               w_accept;
    logic               w_req_valid;

    dcache_wbb_tag_counter u_tag_counter (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .inc_i  (w_accept),
        .tag_o  (w_tag)
    );

    assign w_req_valid = (r_state == REQ) && !w_claim;
    assign w_accept    = w_req_valid && l2_req_ready_i;

    // Fixed priority: ack, then eviction, then request issue.
    always_comb begin
        wbb_cmd_o      = CMD_NONE;
        wbb_cmp_tag_o  = '0;
        evict_ready_o  = 1'b0;
        l2_ack_ready_o = 1'b0;
        spurious_ack_o = 1'b0;
        w_claim        = 1'b0;
        w_dec          = 1'b0;
        if (l2_ack_valid_i) begin
            w_claim        = 1'b1;
            l2_ack_ready_o = 1'b1;
            wbb_cmp_tag_o  = l2_ack_tag_i;
            if (wbb_tag_hit_i) begin
                w_dec     = 1'b1;
                wbb_cmd_o = l2_ack_retry_i ? CMD_WUP : CMD_CLR;
            end else begin
                spurious_ack_o = 1'b1;
            end
        end else if (evict_valid_i) begin
            // On a line hit the WBB's tag_hit flags that the replaced entry was waiting.
            if (wbb_line_hit_i) begin
                w_claim       = 1'b1;
                evict_ready_o = 1'b1;
                wbb_cmd_o     = CMD_SWITCH;
                w_dec         = wbb_tag_hit_i;
            end else if (!wbb_full_i) begin
                w_claim       = 1'b1;
                evict_ready_o = 1'b1;
                wbb_cmd_o     = CMD_ADD;
            end
        end else if (w_accept) begin
            wbb_cmd_o = CMD_PUT_WAIT;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= IDLE;
            r_outst <= '0;
        end else begin
            if (w_accept && r_outst != OUTST_W'(MAX_OUTST)) begin
                r_outst <= r_outst + OUTST_W'(1);
            end else if (w_dec && r_outst != '0) begin
                r_outst <= r_outst - OUTST_W'(1);
            end
            case (r_state)
                IDLE: begin
                    if (wbb_req_avail_i && r_outst < OUTST_W'(MAX_OUTST)) begin
                        r_state <= REQ;
                    end
                end
                REQ: begin
                    if (w_accept || !wbb_req_avail_i) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign l2_req_valid_o = w_req_valid;
    assign l2_req_tag_o   = w_tag;
    assign wbb_new_tag_o  = w_tag;

endmodule

// File: tb/tb_dcache_wbb_ctrl.sv
// Directed bench for the WBB controller: arbitration, request handshake,
// outstanding limit and spurious-ack detection.
module tb_dcache_wbb_ctrl;
    import memory_pkg::*;

    logic     clk_i = 1'b0;
    logic     rst_ni = 1'b0;
    logic     evict_valid_i = 1'b0;
    logic     evict_ready_o;
    logic     l2_ack_valid_i = 1'b0;
    wbb_tag_t l2_ack_tag_i = '0;
    logic     l2_ack_retry_i = 1'b0;
    logic     l2_ack_ready_o;
    logic     l2_req_valid_o;
    wbb_tag_t l2_req_tag_o;
    logic     l2_req_ready_i = 1'b0;
    logic     wbb_line_hit_i = 1'b0;
    logic     wbb_tag_hit_i = 1'b0;
    logic     wbb_req_avail_i = 1'b0;
    logic     wbb_full_i = 1'b0;
    wbb_cmd_e wbb_cmd_o;
    wbb_tag_t wbb_cmp_tag_o;
    wbb_tag_t wbb_new_tag_o;
    logic     spurious_ack_o;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk_i = ~clk_i;

    dcache_wbb_ctrl dut (
        .clk_i           (clk_i),
        .rst_ni          (rst_ni),
        .evict_valid_i   (evict_valid_i),
        .evict_ready_o   (evict_ready_o),
        .l2_ack_valid_i  (l2_ack_valid_i),
        .l2_ack_tag_i    (l2_ack_tag_i),
        .l2_ack_retry_i  (l2_ack_retry_i),
        .l2_ack_ready_o  (l2_ack_ready_o),
        .l2_req_valid_o  (l2_req_valid_o),
        .l2_req_tag_o    (l2_req_tag_o),
        .l2_req_ready_i  (l2_req_ready_i),
        .wbb_line_hit_i  (wbb_line_hit_i),
        .wbb_tag_hit_i   (wbb_tag_hit_i),
        .wbb_req_avail_i (wbb_req_avail_i),
        .wbb_full_i      (wbb_full_i),
        .wbb_cmd_o       (wbb_cmd_o),
        .wbb_cmp_tag_o   (wbb_cmp_tag_o),
        .wbb_new_tag_o   (wbb_new_tag_o),
        .spurious_ack_o  (spurious_ack_o)
    );

    task automatic chk(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end else begin
            $display("ok   %s = %0d", tag, got);
        end
    endtask

    // Inputs change just after the falling edge; outputs are sampled 1 ns later.
    task automatic next_cycle();
        @(negedge clk_i);
    endtask

    initial begin
        #12;
        chk("rst_cmd", int'(wbb_cmd_o), int'(CMD_NONE));
        chk("rst_req_valid", int'(l2_req_valid_o), 0);
        chk("rst_evict_ready", int'(evict_ready_o), 0);
        chk("rst_ack_ready", int'(l2_ack_ready_o), 0);
        chk("rst_new_tag", int'(wbb_new_tag_o), 0);
        chk("rst_spurious", int'(spurious_ack_o), 0);
        chk("rst_outst", int'(dut.r_outst), 0);
        next_cycle();
        rst_ni = 1'b1;

        // 1: eviction into empty buffer, then request becomes available
        next_cycle();
        evict_valid_i = 1'b1;
        #1;
        chk("t1_cmd_add", int'(wbb_cmd_o), int'(CMD_ADD));
        chk("t1_evict_ready", int'(evict_ready_o), 1);
        next_cycle();
        evict_valid_i = 1'b0;
        wbb_req_avail_i = 1'b1;
        #1;
        chk("t1_idle_valid", int'(l2_req_valid_o), 0);
        next_cycle();
        #1;
        chk("t1_req_valid", int'(l2_req_valid_o), 1);
        chk("t1_req_tag", int'(l2_req_tag_o), 0);

        // 2: request held while L2 not ready, then accepted
        for (int i = 0; i < 3; i++) begin
            next_cycle();
            #1;
            chk($sformatf("t2_hold_valid%0d", i), int'(l2_req_valid_o), 1);
            chk($sformatf("t2_hold_tag%0d", i), int'(l2_req_tag_o), 0);
            chk($sformatf("t2_hold_cmd%0d", i), int'(wbb_cmd_o), int'(CMD_NONE));
        end
        next_cycle();
        l2_req_ready_i = 1'b1;
        #1;
        chk("t2_cmd_put_wait", int'(wbb_cmd_o), int'(CMD_PUT_WAIT));
        next_cycle();
        l2_req_ready_i = 1'b0;
        wbb_req_avail_i = 1'b0;
        #1;
        chk("t2_tag_ctr", int'(wbb_new_tag_o), 1);
        chk("t2_outst", int'(dut.r_outst), 1);
        chk("t2_idle_valid", int'(l2_req_valid_o), 0);

        // 3: ack hit clears, ack hit with retry wakes up
        next_cycle();
        l2_ack_valid_i = 1'b1;
        l2_ack_tag_i = 3'd0;
        wbb_tag_hit_i = 1'b1;
        #1;
        chk("t3_cmd_clr", int'(wbb_cmd_o), int'(CMD_CLR));
        chk("t3_ack_ready", int'(l2_ack_ready_o), 1);
        next_cycle();
        l2_ack_retry_i = 1'b1;
        #1;
        chk("t3_outst_after_clr", int'(dut.r_outst), 0);
        chk("t3_cmd_wup", int'(wbb_cmd_o), int'(CMD_WUP));
        next_cycle();
        l2_ack_valid_i = 1'b0;
        l2_ack_retry_i = 1'b0;
        wbb_tag_hit_i = 1'b0;
        #1;
        chk("t3_outst_no_underflow", int'(dut.r_outst), 0);

        // 4: ack beats eviction; eviction served next cycle
        next_cycle();
        l2_ack_valid_i = 1'b1;
        l2_ack_tag_i = 3'd5;
        wbb_tag_hit_i = 1'b1;
        evict_valid_i = 1'b1;
        #1;
        chk("t4_cmd_clr", int'(wbb_cmd_o), int'(CMD_CLR));
        chk("t4_evict_blocked", int'(evict_ready_o), 0);
        chk("t4_cmp_tag", int'(wbb_cmp_tag_o), 5);
        next_cycle();
        l2_ack_valid_i = 1'b0;
        wbb_tag_hit_i = 1'b0;
        #1;
        chk("t4_cmd_add", int'(wbb_cmd_o), int'(CMD_ADD));
        chk("t4_evict_ready", int'(evict_ready_o), 1);
        chk("t4_cmp_tag_zero", int'(wbb_cmp_tag_o), 0);

        // 5: full buffer stalls eviction
        wbb_full_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            next_cycle();
            #1;
            chk($sformatf("t5_stall_ready%0d", i), int'(evict_ready_o), 0);
            chk($sformatf("t5_stall_cmd%0d", i), int'(wbb_cmd_o), int'(CMD_NONE));
        end
        next_cycle();
        wbb_full_i = 1'b0;
        #1;
        chk("t5_unstall_ready", int'(evict_ready_o), 1);
        chk("t5_unstall_cmd", int'(wbb_cmd_o), int'(CMD_ADD));
        next_cycle();
        evict_valid_i = 1'b0;

        // 6: two accepted requests reach the limit; spurious ack
        wbb_req_avail_i = 1'b1;
        l2_req_ready_i = 1'b1;
        #1;
        chk("t6_s1_valid", int'(l2_req_valid_o), 0);
        next_cycle();
        #1;
        chk("t6_s2_valid", int'(l2_req_valid_o), 1);
        chk("t6_s2_tag", int'(l2_req_tag_o), 1);
        chk("t6_s2_cmd", int'(wbb_cmd_o), int'(CMD_PUT_WAIT));
        next_cycle();
        #1;
        chk("t6_s3_valid", int'(l2_req_valid_o), 0);
        chk("t6_s3_new_tag", int'(wbb_new_tag_o), 2);
        next_cycle();
        #1;
        chk("t6_s4_valid", int'(l2_req_valid_o), 1);
        chk("t6_s4_tag", int'(l2_req_tag_o), 2);
        for (int i = 0; i < 3; i++) begin
            next_cycle();
            #1;
            chk($sformatf("t6_limit_valid%0d", i), int'(l2_req_valid_o), 0);
            chk($sformatf("t6_limit_outst%0d", i), int'(dut.r_outst), 2);
        end
        chk("t6_new_tag", int'(wbb_new_tag_o), 3);
        next_cycle();
        l2_ack_valid_i = 1'b1;
        l2_ack_tag_i = 3'd7;
        #1;
        chk("t6_spurious", int'(spurious_ack_o), 1);
        chk("t6_spurious_cmd", int'(wbb_cmd_o), int'(CMD_NONE));
        chk("t6_spurious_ack_ready", int'(l2_ack_ready_o), 1);
        next_cycle();
        l2_ack_tag_i = 3'd1;
        wbb_tag_hit_i = 1'b1;
        #1;
        chk("t6_spurious_pulse_end", int'(spurious_ack_o), 0);
        chk("t6_outst_kept", int'(dut.r_outst), 2);
        chk("t6_cmd_clr", int'(wbb_cmd_o), int'(CMD_CLR));

        // 7: eviction switch masks a pending request for one cycle
        next_cycle();
        l2_ack_valid_i = 1'b0;
        wbb_tag_hit_i = 1'b0;
        #1;
        chk("t7_outst_dec", int'(dut.r_outst), 1);
        chk("t7_idle_valid", int'(l2_req_valid_o), 0);
        next_cycle();
        evict_valid_i = 1'b1;
        wbb_line_hit_i = 1'b1;
        #1;
        chk("t7_cmd_switch", int'(wbb_cmd_o), int'(CMD_SWITCH));
        chk("t7_switch_ready", int'(evict_ready_o), 1);
        chk("t7_masked_valid", int'(l2_req_valid_o), 0);
        next_cycle();
        evict_valid_i = 1'b0;
        wbb_line_hit_i = 1'b0;
        #1;
        chk("t7_unmasked_valid", int'(l2_req_valid_o), 1);
        chk("t7_unmasked_tag", int'(l2_req_tag_o), 3);
        chk("t7_cmd_put_wait", int'(wbb_cmd_o), int'(CMD_PUT_WAIT));
        next_cycle();
        wbb_req_avail_i = 1'b0;
        l2_req_ready_i = 1'b0;
        #1;
        chk("t7_new_tag", int'(wbb_new_tag_o), 4);
        chk("t7_outst", int'(dut.r_outst), 2);
        next_cycle();
        evict_valid_i = 1'b1;
        wbb_line_hit_i = 1'b1;
        wbb_tag_hit_i = 1'b1;
        #1;
        chk("t7_switch_waiting", int'(wbb_cmd_o), int'(CMD_SWITCH));
        next_cycle();
        evict_valid_i = 1'b0;
        wbb_line_hit_i = 1'b0;
        wbb_tag_hit_i = 1'b0;
        #1;
        chk("t7_switch_dec", int'(dut.r_outst), 1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
